// File: rtl/acc_uart_tx.sv
// Accumulator-fed UART transmitter: one-entry holding register in front of an LSB-first shifter.
// Define ACC_UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit (8E1).
`timescale 1ns/1ps
module acc_uart_tx #(
    parameter int CLK_DIV = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       out_req,
    input  logic [7:0] acc_data,
    output logic       out_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       ovf_err,
    output logic       tx
);

    localparam int CW = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    generate
        if (CLK_DIV < 2) begin : g_div_check
            $error("acc_uart_tx: CLK_DIV must be >= 2");
        end
    endgenerate

`ifdef ACC_UART_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [2:0]      bit_idx_reg, bit_idx_next;
    logic [7:0]      shift_reg, shift_next;
    logic [7:0]      hold_reg, hold_next;
    logic            hold_full_reg, hold_full_next;
    logic            tx_reg, tx_next;
    logic            done_reg, done_next;
    logic            ovf_reg, ovf_next;
    logic            load;
`ifdef ACC_UART_PARITY_EN
    logic            parity_reg, parity_next;
`endif

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        bit_idx_next   = bit_idx_reg;
        shift_next     = shift_reg;
        hold_next      = hold_reg;
        hold_full_next = hold_full_reg;
        tx_next        = tx_reg;
        done_next      = 1'b0;
        ovf_next       = ovf_reg | (out_req & hold_full_reg);
        load           = 1'b0;
`ifdef ACC_UART_PARITY_EN
        parity_next    = parity_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (hold_full_reg) load = 1'b1;
            end
            S_START: begin
                if (cnt_reg == '0) begin
                    state_next   = S_DATA;
                    cnt_next     = RELOAD;
                    bit_idx_next = 3'd0;
                    tx_next      = shift_reg[0];
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_reg == '0) begin
                    cnt_next = RELOAD;
                    if (bit_idx_reg == 3'd7) begin
`ifdef ACC_UART_PARITY_EN
                        state_next = S_PARITY;
                        tx_next    = parity_reg;
`else
                        state_next = S_STOP;
                        tx_next    = 1'b1;
`endif
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                        shift_next   = {1'b0, shift_reg[7:1]};
                        tx_next      = shift_reg[1];
                    end
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
`ifdef ACC_UART_PARITY_EN
            S_PARITY: begin
                if (cnt_reg == '0) begin
                    state_next = S_STOP;
                    cnt_next   = RELOAD;
                    tx_next    = 1'b1;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
`endif
            S_STOP: begin
                // Registered, so the pulse lands on the stop bit's final cycle (counter = 0).
                if (cnt_reg == CW'(1)) done_next = 1'b1;
                if (cnt_reg == '0) begin
                    if (hold_full_reg) load = 1'b1;
                    else               state_next = S_IDLE;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase

        if (load) begin
            state_next     = S_START;
            shift_next     = hold_reg;
            hold_full_next = 1'b0;
            tx_next        = 1'b0;
            cnt_next       = RELOAD;
`ifdef ACC_UART_PARITY_EN
            parity_next    = ^hold_reg;
`endif
        end

        // Accept only sees the pre-edge fullness, so a same-edge transfer always moves the older byte.
        if (out_req && !hold_full_reg) begin
            hold_next      = acc_data;
            hold_full_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            bit_idx_reg   <= 3'd0;
            shift_reg     <= 8'd0;
            hold_reg      <= 8'd0;
            hold_full_reg <= 1'b0;
            tx_reg        <= 1'b1;
            done_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
`ifdef ACC_UART_PARITY_EN
            parity_reg    <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            bit_idx_reg   <= bit_idx_next;
            shift_reg     <= shift_next;
            hold_reg      <= hold_next;
            hold_full_reg <= hold_full_next;
            tx_reg        <= tx_next;
            done_reg      <= done_next;
            ovf_reg       <= ovf_next;
`ifdef ACC_UART_PARITY_EN
            parity_reg    <= parity_next;
`endif
        end
    end

    assign out_ready = !hold_full_reg;
    assign tx_busy   = (state_reg != S_IDLE) || hold_full_reg;
    assign tx_done   = done_reg;
    assign ovf_err   = ovf_reg;
    assign tx        = tx_reg;

endmodule

// File: tb/tb_acc_uart_tx.sv
// Bench for acc_uart_tx (CLK_DIV=4): table vectors, directed corner sequences and a
// random run, all checked every cycle against a frame-timeline reference model.
`timescale 1ns/1ps
module tb_acc_uart_tx;

    localparam int DIV = 4;
`ifdef ACC_UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       out_req = 1'b0;
    logic [7:0] acc_data = 8'd0;
    logic       out_ready, tx_busy, tx_done, ovf_err, tx;

    int checks = 0;
    int errors = 0;

    acc_uart_tx #(.CLK_DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .out_req(out_req), .acc_data(acc_data),
        .out_ready(out_ready), .tx_busy(tx_busy), .tx_done(tx_done),
        .ovf_err(ovf_err), .tx(tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Line level of bit slot idx of a frame carrying b: start, 8 data LSB-first, [parity], stop.
    function automatic logic line_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (NBITS == 11 && idx == 9) return ^b;
        return 1'b1;
    endfunction

    // Reference model: a frame is just (start edge, byte); everything else is arithmetic on cycle offsets.
    int         cyc = 0;
    bit         started = 0;
    bit         m_hold_full, m_active, m_ovf;
    logic [7:0] m_hold, m_byte;
    int         m_s;
    int         done_q[$];

    always @(posedge clk) begin
        logic m_tx, m_done;
        int   off;
        cyc++;
        if (!rst_n) begin
            started     = 1;
            m_hold_full = 0;
            m_active    = 0;
            m_ovf       = 0;
        end else if (started) begin
            if (m_active && (cyc - m_s) == FRAME) m_active = 0;
            if (out_req && m_hold_full) m_ovf = 1;
            if (m_hold_full && !m_active) begin
                m_active    = 1;
                m_s         = cyc;
                m_byte      = m_hold;
                m_hold_full = 0;
                if (out_req) begin
                    // request seen while hold was still full at this edge: dropped above
                end
            end else if (out_req && !m_hold_full) begin
                m_hold      = acc_data;
                m_hold_full = 1;
            end
        end
        #1;
        if (started) begin
            off    = cyc - m_s;
            m_tx   = m_active ? line_bit(m_byte, off / DIV) : 1'b1;
            m_done = m_active && (off == FRAME - 1);
            check("model_tx", tx, m_tx);
            check("model_ready", out_ready, !m_hold_full);
            check("model_busy", tx_busy, m_active || m_hold_full);
            check("model_done", tx_done, m_done);
            check("model_ovf", ovf_err, m_ovf);
            if (tx_done === 1'b1) done_q.push_back(cyc);
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        out_req  = 1'b1;
        acc_data = b;
        @(posedge clk);
        #1;
        out_req = 1'b0;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && tx_busy !== 1'b0; i++) begin
            @(posedge clk);
            #1;
        end
        check("idle_wait", tx_busy, 1'b0);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 400 && out_ready !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        check("ready_wait", out_ready, 1'b1);
    endtask

    typedef struct {
        logic [7:0] data;
        int         off;
        logic       tx;
        logic       done;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int cur, n0;
        // Offsets are counted in clk edges from the edge that samples out_req.
        vecs.push_back('{8'hA5, 0, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{8'hA5, 1, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{8'hA5, 4, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{8'hA5, 5, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{8'hA5, 9, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{8'hA5, 13, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{8'hA5, 17, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{8'hA5, 21, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{8'hA5, 25, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{8'hA5, 29, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{8'hA5, 33, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{8'hA5, DIV*(NBITS-1)+1, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{8'hA5, DIV*NBITS-1, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{8'hA5, DIV*NBITS, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{8'hA5, DIV*NBITS+1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{8'h00, 5, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{8'h00, 33, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{8'h00, DIV*(NBITS-1)+1, 1'b1, 1'b0, 1'b1});
`ifdef ACC_UART_PARITY_EN
        vecs.push_back('{8'h07, 37, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{8'h07, 44, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{8'h03, 37, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{8'h03, 41, 1'b1, 1'b0, 1'b1});
`endif

        // Reset values
        do_reset(3);
        check("rst_tx", tx, 1'b1);
        check("rst_ready", out_ready, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_ovf", ovf_err, 1'b0);
        check("rst_done", tx_done, 1'b0);

        // Table vectors: a new frame starts whenever the offset sequence restarts
        cur = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            if (i == 0 || vecs[i].off <= vecs[i-1].off) begin
                wait_idle();
                send(vecs[i].data);
                cur = 0;
            end
            while (cur < vecs[i].off) begin
                @(posedge clk);
                #1;
                cur++;
            end
            check("vec_tx", tx, vecs[i].tx);
            check("vec_done", tx_done, vecs[i].done);
            check("vec_busy", tx_busy, vecs[i].busy);
        end
        wait_idle();

        // Back-to-back: second start bit directly follows the first stop bit
        n0 = done_q.size();
        send(8'h01);
        wait_ready();
        send(8'hFF);
        wait_idle();
        check("b2b_done_count", done_q.size(), n0 + 2);
        if (done_q.size() == n0 + 2)
            check("b2b_done_spacing", done_q[n0+1] - done_q[n0], FRAME);

        // Overflow: third request while hold is full is dropped, flag is sticky
        send(8'h11);
        wait_ready();
        send(8'h22);
        check("ovf_clear_before", ovf_err, 1'b0);
        send(8'h33);
        check("ovf_set", ovf_err, 1'b1);
        wait_idle();
        check("ovf_sticky", ovf_err, 1'b1);

        // Reset during data bit 3 with a byte queued
        send(8'hC3);
        wait_ready();
        send(8'h5A);
        repeat (15) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst_tx", tx, 1'b1);
        check("midrst_busy", tx_busy, 1'b0);
        check("midrst_ovf", ovf_err, 1'b0);
        n0 = done_q.size();
        repeat (60) @(posedge clk);
        #1;
        check("midrst_no_done", done_q.size(), n0);
        send(8'h96);
        wait_idle();
        check("midrst_resume_done", done_q.size(), n0 + 1);

        // Random traffic, including requests while full and occasional resets
        for (int i = 0; i < 250; i++) begin
            repeat ($urandom_range(0, 50)) @(posedge clk);
            if ($urandom_range(0, 39) == 0) do_reset($urandom_range(1, 3));
            else send(8'($urandom));
        end
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
